// File: rtl/readout_sequencer.sv
// readout_sequencer: serializes pixel bytes MSB-first into a line shift register and pulses load per line
module readout_sequencer #(
    parameter int PIXELS_PER_LINE = 1024,
    parameter int LINES_PER_FRAME = 1024,
    localparam int PW = PIXELS_PER_LINE > 1 ? $clog2(PIXELS_PER_LINE) : 1,
    localparam int LW = LINES_PER_FRAME > 1 ? $clog2(LINES_PER_FRAME) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          shift_in,
    output logic          shift_en,
    output logic          load,
    output logic          busy,
    output logic          line_done,
    output logic          frame_done,
    output logic [LW-1:0] line_count
);
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LOAD} state_t;
    state_t state, state_nxt;
    logic [7:0] pix_byte;
    logic [2:0] bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic last_pix, last_line, xfer;
    assign last_pix = pix_cnt == PW'(PIXELS_PER_LINE - 1);
    assign last_line = line_count == LW'(LINES_PER_FRAME - 1);
    assign xfer = pix_valid & pix_ready;
    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    // next state; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? FETCH : IDLE;
            FETCH:   state_nxt = xfer ? SHIFT : FETCH;
            SHIFT:   state_nxt = bit_cnt != 3'd0 ? SHIFT : last_pix ? LOAD : xfer ? SHIFT : FETCH;
            LOAD:    state_nxt = last_line ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end
    // outputs; the last bit slot of a non-final pixel also accepts the next byte for gapless shifting
    always_comb begin
        busy = state != IDLE;
        shift_en = state == SHIFT;
        shift_in = shift_en & pix_byte[bit_cnt];
        pix_ready = !abort && (state == FETCH || (shift_en && bit_cnt == 3'd0 && !last_pix));
        load = !abort && state == LOAD;
        line_done = load;
        frame_done = load && last_line;
    end
    // byte holding register plus bit, pixel and line counters
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pix_byte <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            line_count <= '0;
        end else if (abort) begin
            pix_byte <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            line_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pix_cnt <= '0;
                    line_count <= '0;
                end
                FETCH: if (xfer) begin
                    pix_byte <= pix_data;
                    bit_cnt <= 3'd7;
                end
                SHIFT: if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
                else if (!last_pix) begin
                    pix_cnt <= pix_cnt + PW'(1);
                    if (xfer) begin
                        pix_byte <= pix_data;
                        bit_cnt <= 3'd7;
                    end
                end
                LOAD: begin
                    pix_cnt <= '0;
                    line_count <= last_line ? '0 : line_count + LW'(1);
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized checks of the readout sequencer against a line/bitstream model
module tb_readout_sequencer;
    localparam int P = 4;
    localparam int L = 2;
    localparam int W = 8 * P;
    logic clk = 0;
    logic reset = 1, start = 0, abort = 0, pix_valid = 0;
    logic [7:0] pix_data = 0;
    logic pix_ready, shift_in, shift_en, load, busy, line_done, frame_done;
    logic [0:0] line_count;
    readout_sequencer #(.PIXELS_PER_LINE(P), .LINES_PER_FRAME(L)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .shift_in(shift_in), .shift_en(shift_en), .load(load), .busy(busy),
        .line_done(line_done), .frame_done(frame_done), .line_count(line_count)
    );
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc, popped, stall_after, stall_left, valid_pct, nshift, viol, busy_cycles;
    logic [7:0] src[$];
    logic [7:0] exp_bytes[$];
    logic [W-1:0] sr;
    logic [W-1:0] words[$];
    int loads[$];
    int frames[$];
    int shifts_q[$];
    bit bits[$];
    bit busy_hist[200];

    function automatic logic [W-1:0] exp_word(int line);
        logic [W-1:0] w = '0;
        for (int i = 0; i < P; i++) w = {w[W-9:0], exp_bytes[line*P+i]};
        return w;
    endfunction

    function automatic logic [W-1:0] stream_word(int off);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], bits[off+i]};
        return w;
    endfunction

    task automatic clear_model();
        src.delete(); exp_bytes.delete(); words.delete(); loads.delete();
        frames.delete(); shifts_q.delete(); bits.delete();
        cyc = 0; popped = 0; stall_after = -1; stall_left = 0; valid_pct = 100;
        nshift = 0; viol = 0; busy_cycles = 0; sr = '0;
        for (int i = 0; i < 200; i++) busy_hist[i] = 0;
    endtask

    task automatic fill(int n);
        logic [7:0] b;
        repeat (n) begin
            b = 8'($urandom);
            src.push_back(b);
            exp_bytes.push_back(b);
        end
    endtask

    // one clock cycle: drive source, observe at negedge, commit transfer after the edge
    task automatic cycle();
        bit xfer;
        pix_data = src.size() > 0 ? src[0] : 8'h00;
        pix_valid = src.size() > 0 && !(popped == stall_after && stall_left > 0)
                    && ($urandom_range(99) < valid_pct);
        @(negedge clk);
        if (pix_ready && !shift_en && popped == stall_after && stall_left > 0) stall_left--;
        if (shift_en) begin
            bits.push_back(shift_in);
            sr = {sr[W-2:0], shift_in};
            nshift++;
        end else if (shift_in) viol++;
        if (line_done !== load || (frame_done && !load)) viol++;
        if (abort && pix_ready) viol++;
        if (load) begin
            loads.push_back(cyc);
            words.push_back(sr);
            shifts_q.push_back(nshift);
            nshift = 0;
        end
        if (frame_done) frames.push_back(cyc);
        if (busy) busy_cycles++;
        if (cyc >= 0 && cyc < 200) busy_hist[cyc] = busy;
        xfer = pix_valid & pix_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (xfer) begin
            void'(src.pop_front());
            popped++;
        end
    endtask

    task automatic run_until(int c);
        while (cyc <= c) cycle();
    endtask

    task automatic start_frame();
        cyc = 0;
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic go_idle();
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_reset();
        clear_model();
        start = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({pix_ready, shift_in, shift_en, load, busy, line_done, frame_done, line_count} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {pix_ready, shift_in, shift_en, load, busy, line_done, frame_done, line_count});
        end
        start = 0;
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_single_line();
        logic [7:0] fixed[4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        go_idle();
        clear_model();
        for (int i = 0; i < 4; i++) begin
            src.push_back(fixed[i]);
            exp_bytes.push_back(fixed[i]);
        end
        start_frame();
        run_until(35);
        tests++;
        if ((loads.size() > 0 ? loads[0] : -1) !== 34) begin
            fails++;
            $display("FAIL line_load_cycle: got %0d expected 34", loads.size() > 0 ? loads[0] : -1);
        end
        tests++;
        if ((words.size() > 0 ? words[0] : '0) !== 32'hA53CFF01) begin
            fails++;
            $display("FAIL line_word: got %h expected a53cff01", words.size() > 0 ? words[0] : '0);
        end
        tests++;
        if (bits.size() != W || stream_word(0) !== 32'b1010_0101_0011_1100_1111_1111_0000_0001) begin
            fails++;
            $display("FAIL line_stream: got %0d bits %b expected 32 bits a53cff01", bits.size(),
                     bits.size() >= W ? stream_word(0) : '0);
        end
        tests++;
        if (line_count !== 1'b1) begin
            fails++;
            $display("FAIL line_count_after_load: got %0d expected 1", line_count);
        end
        tests++;
        if ((shifts_q.size() > 0 ? shifts_q[0] : -1) !== W || viol !== 0) begin
            fails++;
            $display("FAIL line_shift_count: got %0d shifts, %0d protocol errors expected %0d, 0",
                     shifts_q.size() > 0 ? shifts_q[0] : -1, viol, W);
        end
    endtask

    task automatic test_frame();
        go_idle();
        clear_model();
        fill(2 * P);
        start_frame();
        run_until(9);
        start = 1;
        cycle();
        start = 0;
        run_until(70);
        tests++;
        if (loads.size() != 2 || loads[0] !== 34 || loads[1] !== 68) begin
            fails++;
            $display("FAIL frame_load_cycles: got %0d loads first %0d expected 2 loads at 34,68",
                     loads.size(), loads.size() > 0 ? loads[0] : -1);
        end
        tests++;
        if ((frames.size() == 1 ? frames[0] : -1) !== 68) begin
            fails++;
            $display("FAIL frame_done_cycle: got %0d pulses expected one at 68", frames.size());
        end
        tests++;
        if ({busy_hist[68], busy_hist[69]} !== 2'b10) begin
            fails++;
            $display("FAIL frame_busy_fall: got %b expected 10 at cycles 68,69", {busy_hist[68], busy_hist[69]});
        end
        tests++;
        if (words.size() != 2 || words[0] !== exp_word(0) || words[1] !== exp_word(1)) begin
            fails++;
            $display("FAIL frame_words: got %0d words expected %h %h", words.size(), exp_word(0), exp_word(1));
        end
        tests++;
        if (line_count !== 1'b0 || viol !== 0) begin
            fails++;
            $display("FAIL frame_end_state: got line_count %0d errors %0d expected 0, 0", line_count, viol);
        end
    endtask

    task automatic test_stall();
        int s;
        repeat (3) begin
            go_idle();
            clear_model();
            fill(P);
            stall_after = $urandom_range(1, P - 1);
            s = $urandom_range(1, 5);
            stall_left = s;
            start_frame();
            run_until(W + 4 + s);
            tests++;
            if ((loads.size() > 0 ? loads[0] : -1) !== W + 3 + s) begin
                fails++;
                $display("FAIL stall_load_cycle: got %0d expected %0d (stall %0d after byte %0d)",
                         loads.size() > 0 ? loads[0] : -1, W + 3 + s, s, stall_after);
            end
            tests++;
            if ((words.size() > 0 ? words[0] : '0) !== exp_word(0)) begin
                fails++;
                $display("FAIL stall_word: got %h expected %h", words.size() > 0 ? words[0] : '0, exp_word(0));
            end
            tests++;
            if ((shifts_q.size() > 0 ? shifts_q[0] : -1) !== W || viol !== 0) begin
                fails++;
                $display("FAIL stall_shifts: got %0d shifts %0d errors expected %0d, 0",
                         shifts_q.size() > 0 ? shifts_q[0] : -1, viol, W);
            end
        end
    endtask

    task automatic test_abort();
        int k;
        go_idle();
        clear_model();
        fill(P);
        start_frame();
        k = $urandom_range(0, 7);
        run_until(17 + k);
        abort = 1;
        start = 1;
        cycle();
        abort = 0;
        start = 0;
        tests++;
        if ({busy, line_count} !== 2'b00 || viol !== 0) begin
            fails++;
            $display("FAIL abort_shift: got busy %b line_count %0d errors %0d expected 0 0 0", busy, line_count, viol);
        end
        abort = 1;
        start = 1;
        cycle();
        abort = 0;
        start = 0;
        repeat (40) cycle();
        tests++;
        if (loads.size() !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_load: got %0d loads busy %b expected 0 loads busy 0", loads.size(), busy);
        end
        clear_model();
        fill(P);
        start_frame();
        run_until(35);
        tests++;
        if ((loads.size() > 0 ? loads[0] : -1) !== 34 || (words.size() > 0 ? words[0] : '0) !== exp_word(0)) begin
            fails++;
            $display("FAIL abort_resume: got load at %0d expected 34 with word %h", loads.size() > 0 ? loads[0] : -1, exp_word(0));
        end
        go_idle();
        clear_model();
        fill(P);
        start_frame();
        run_until(33);
        abort = 1;
        cycle();
        abort = 0;
        tests++;
        if (loads.size() !== 0 || frames.size() !== 0 || {busy, line_count} !== 2'b00) begin
            fails++;
            $display("FAIL abort_in_load: got %0d loads busy %b line_count %0d expected 0 0 0", loads.size(), busy, line_count);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        go_idle();
        clear_model();
        fill(P);
        start_frame();
        n = $urandom_range(5, 30);
        run_until(n);
        #2 reset = 1;
        #1;
        tests++;
        if ({pix_ready, shift_in, shift_en, load, busy, line_done, frame_done, line_count} !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b expected 00000000",
                     {pix_ready, shift_in, shift_en, load, busy, line_done, frame_done, line_count});
        end
        repeat (2) cycle();
        reset = 0;
        busy_cycles = 0;
        fill(P);
        repeat (40) cycle();
        tests++;
        if (loads.size() !== 0 || busy_cycles !== 0) begin
            fails++;
            $display("FAIL reset_mid_idle: got %0d loads %0d busy cycles expected 0 0", loads.size(), busy_cycles);
        end
    endtask

    task automatic test_random_frames();
        repeat (4) begin
            go_idle();
            clear_model();
            fill(L * P);
            valid_pct = $urandom_range(40, 100);
            start_frame();
            while (frames.size() == 0 && cyc < 2000) cycle();
            tests++;
            if (frames.size() !== 1 || busy !== 1'b0 || line_count !== 1'b0) begin
                fails++;
                $display("FAIL rand_frame_end: got %0d frame_done busy %b line_count %0d expected 1 0 0 (timeout at %0d)",
                         frames.size(), busy, line_count, cyc);
            end
            tests++;
            if (words.size() != 2 || words[0] !== exp_word(0) || words[1] !== exp_word(1)) begin
                fails++;
                $display("FAIL rand_frame_words: got %0d words expected %h %h", words.size(), exp_word(0), exp_word(1));
            end
            tests++;
            if (shifts_q.size() != 2 || shifts_q[0] !== W || shifts_q[1] !== W || viol !== 0) begin
                fails++;
                $display("FAIL rand_frame_shifts: got %0d loads %0d errors expected 2 loads of %0d shifts, 0 errors",
                         shifts_q.size(), viol, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_frame();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
